// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
//
// Contents:
//   loader_state_t    loader FSM states
//   LOADER_HDR_BYTES  header length in bytes (word count + start PC)
//   loader_accepts()  1 in the states that take stream bytes
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    LD_LEN  = 3'd0,
    LD_PC   = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_RUN  = 3'd4,
    LD_ERR  = 3'd5
  } loader_state_t;

  localparam int LOADER_HDR_BYTES = 8;

  function automatic logic loader_accepts(input loader_state_t s);
    return (s == LD_LEN) || (s == LD_PC) || (s == LD_DATA) || (s == LD_CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// rtl/imem_boot_loader_byte_packer.sv - little-endian 8-to-32 word assembler
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   clear      in   discard any partially assembled word
//   byte_valid in   accepted byte this cycle
//   byte_data  in   byte value
//   word       out  assembled word, valid while word_done is high
//   word_done  out  1-cycle strobe on the 4th accepted byte
module imem_boot_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  // The first three bytes sit in shreg (byte 0 lowest after three shifts);
  // the fourth byte is merged combinationally so the word can be written on
  // the same edge that accepts it.
  assign word      = {byte_data, shreg};
  assign word_done = byte_valid && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {byte_data, shreg[23:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - instruction RAM with byte-stream boot loader and core reset control
//
// Optional feature macro: IMEM_BOOT_LOADER_CHECKSUM_EN (adds a 4-byte sum-of-words trailer check)
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   boot byte valid
//   in_data      in   boot byte
//   in_ready     out  loader accepts a byte (LEN/PC/DATA/CSUM)
//   reload       in   pulse in RUN/ERR restarts the load
//   imem_addr    in   core fetch byte address, bits [1:0] ignored
//   imem_rdata   out  combinational RAM read data
//   init_pc      out  start PC from the header
//   core_reset_n out  active-low core reset, released one cycle after RUN entry
//   busy         out  load in progress
//   err          out  loader in ERR
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IADDR = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             reload,
  input  logic [IADDR-1:0] imem_addr,
  output logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] init_pc,
  output logic             core_reset_n,
  output logic             busy,
  output logic             err
);

  localparam int               DEPTH   = 2 ** (IADDR - 2);
  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = LD_CSUM;
`else
  localparam loader_state_t AFTER_DATA = LD_RUN;
`endif

  loader_state_t    state;
  logic [IADDR-2:0] word_cnt;   // one bit wider than the RAM index so N == DEPTH fits
  logic [WIDTH-1:0] n_words;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             xfer;
  logic             restart;
  logic             last_word;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             unused_addr_lsbs;

  assign in_ready  = loader_accepts(state);
  assign busy      = in_ready;
  assign err       = (state == LD_ERR);
  assign xfer      = in_valid && in_ready;
  assign restart   = reload && ((state == LD_RUN) || (state == LD_ERR));
  assign last_word = (WIDTH'(word_cnt) == n_words - WIDTH'(1));

  assign imem_rdata       = mem[imem_addr[IADDR-1:2]];
  assign unused_addr_lsbs = ^imem_addr[1:0];

  imem_boot_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (xfer),
    .byte_data  (in_data),
    .word       (word),
    .word_done  (word_done)
  );

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_acc;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      csum_acc <= '0;
    end else if (word_done && (state == LD_DATA)) begin
      csum_acc <= csum_acc + word;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LD_LEN;
      word_cnt     <= '0;
      n_words      <= '0;
      init_pc      <= '0;
      core_reset_n <= 1'b0;
    end else begin
      // Registered off the state so init_pc has settled a full cycle before release.
      core_reset_n <= (state == LD_RUN) && !reload;
      if (restart) begin
        state    <= LD_LEN;
        word_cnt <= '0;
      end else if (word_done) begin
        case (state)
          LD_LEN: begin
            n_words <= word;
            state   <= (word > DEPTH_W) ? LD_ERR : LD_PC;
          end
          LD_PC: begin
            init_pc <= word;
            state   <= (n_words == '0) ? LD_RUN : LD_DATA;
          end
          LD_DATA: begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) state <= AFTER_DATA;
          end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
          LD_CSUM: begin
            state <= (word == csum_acc) ? LD_RUN : LD_ERR;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // No reset on the array: contents survive reset and reload by design.
  always_ff @(posedge clk) begin
    if (!reset && word_done && (state == LD_DATA)) begin
      mem[word_cnt[IADDR-3:0]] <= word;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed-vector bench for imem_boot_loader
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic [9:0]  imem_addr = 10'd0;
  logic [31:0] imem_rdata;
  logic [31:0] init_pc;
  logic        core_reset_n;
  logic        busy;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.WIDTH(32), .IADDR(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .init_pc      (init_pc),
    .core_reset_n (core_reset_n),
    .busy         (busy),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic pulse_reload;
    reload = 1'b1;
    tick;
    reload = 1'b0;
  endtask

  // gap idle cycles precede each byte so sampling right after the last byte is aligned
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick;
    in_valid = 1'b1;
    in_data  = b;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_trailer(input logic [31:0] w, input int gap);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send_word(w, gap);
`else
    if (gap < 0) send_word(w, 0);
`endif
  endtask

  task automatic read_word(input string tag, input logic [9:0] addr, input logic [31:0] exp);
    imem_addr = addr;
    #1;
    check(tag, imem_rdata, exp);
  endtask

  initial begin
    do_reset;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
    check("rst_init_pc", init_pc, 32'd0);

    // Test 1: basic two-word image
    send_word(32'd2, 0);
    send_word(32'h0000_0100, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_trailer(32'h0010_00A6, 0);
    check("t1_core_reset_n_edge", 32'(core_reset_n), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    tick;
    check("t1_core_reset_n", 32'(core_reset_n), 32'd1);
    check("t1_init_pc", init_pc, 32'h0000_0100);
    read_word("t1_ram0", 10'd0, 32'h0000_0013);
    read_word("t1_ram1", 10'd7, 32'h0010_0093);

    // Test 2: empty payload
    pulse_reload;
    check("t2_reload_core_reset_n", 32'(core_reset_n), 32'd0);
    check("t2_reload_busy", 32'(busy), 32'd1);
    send_word(32'd0, 0);
    send_word(32'h0000_0040, 0);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_init_pc", init_pc, 32'h0000_0040);
    read_word("t2_ram0", 10'd0, 32'h0000_0013);
    tick;
    check("t2_core_reset_n", 32'(core_reset_n), 32'd1);

    // Test 3: N == depth accepted, N == depth+1 rejected
    pulse_reload;
    send_word(32'd256, 0);
    check("t3_depth_err", 32'(err), 32'd0);
    check("t3_depth_busy", 32'(busy), 32'd1);
    do_reset;
    send_word(32'd257, 0);
    check("t3_over_err", 32'(err), 32'd1);
    check("t3_over_in_ready", 32'(in_ready), 32'd0);
    send_byte(8'h55, 0);
    check("t3_ignored_err", 32'(err), 32'd1);
    check("t3_err_core_reset_n", 32'(core_reset_n), 32'd0);
    pulse_reload;
    check("t3_reload_err", 32'(err), 32'd0);
    check("t3_reload_in_ready", 32'(in_ready), 32'd1);

    // Test 4: in_valid toggling every cycle
    send_word(32'd2, 1);
    send_word(32'h0000_0200, 1);
    send_word(32'hDEAD_BEEF, 1);
    send_word(32'h0123_4567, 1);
    send_trailer(32'hDFD1_0456, 1);
    check("t4_busy", 32'(busy), 32'd0);
    tick;
    check("t4_core_reset_n", 32'(core_reset_n), 32'd1);
    check("t4_init_pc", init_pc, 32'h0000_0200);
    read_word("t4_ram0", 10'd0, 32'hDEAD_BEEF);
    read_word("t4_ram1", 10'd4, 32'h0123_4567);

    // Test 5: reset mid-word, then a fresh image
    do_reset;
    send_word(32'd3, 0);
    send_word(32'h0000_0500, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset;
    read_word("t5_partial_ram0", 10'd0, 32'hDEAD_BEEF);
    pulse_reload;
    check("t5_reload_in_len_busy", 32'(busy), 32'd1);
    send_word(32'd1, 0);
    send_word(32'h0000_0300, 0);
    send_word(32'hCAFE_F00D, 0);
    send_trailer(32'hCAFE_F00D, 0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_init_pc", init_pc, 32'h0000_0300);
    read_word("t5_ram0", 10'd0, 32'hCAFE_F00D);
    read_word("t5_ram1", 10'd4, 32'h0123_4567);
    tick;
    check("t5_core_reset_n", 32'(core_reset_n), 32'd1);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    // Test 6: checksum mismatch
    pulse_reload;
    send_word(32'd2, 0);
    send_word(32'h0000_0100, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'h0010_00A7, 0);
    check("t6_err", 32'(err), 32'd1);
    tick;
    check("t6_core_reset_n", 32'(core_reset_n), 32'd0);
    check("t6_err_hold", 32'(err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
